// File: rtl/pipeline_hazard_ctrl.sv
// Purpose : hazard/stall sequencer for the 5-stage RV32 pipeline (load-use, redirect, data-memory handshake).
// Latency : all control outputs are combinational from inputs and state; zero-cycle latency.
// Backpressure: a data-memory access that is not ready freezes every stage and bubbles MEM/WB until done or timeout.
//
// Ports:
//   clk, reset                      clock, asynchronous active-high reset
//   id_rs1, id_rs2                  source registers of the ID instruction
//   ex_rd, ex_mem_read              destination / MemRead of the EX instruction
//   ex_redirect                     EX resolved a taken branch or holds JAL/JALR
//   mem_read, mem_write, mem_ready  MEM-stage access type and memory completion
//   mem_req                         data-memory request
//   pc_write_en .. ex_mem_write_en  stage register load enables
//   if_id_flush, id_ex_flush        load NOP into IF/ID, ID/EX
//   mem_wb_bubble                   load NOP into MEM/WB
//   mem_err                         sticky memory-timeout flag
//   stall_cnt, flush_cnt            saturating performance counters
module pipeline_hazard_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_redirect,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             pc_write_en,
  output logic             if_id_write_en,
  output logic             id_ex_write_en,
  output logic             ex_mem_write_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             mem_wb_bubble,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  // wait_cnt never exceeds TIMEOUT-1, so clog2(TIMEOUT) bits suffice for TIMEOUT >= 2.
  localparam int              WCW       = $clog2(TIMEOUT);
  localparam logic [WCW-1:0]  WAIT_LAST = WCW'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic {
    M_IDLE = 1'b0,
    M_WAIT = 1'b1
  } mstate_t;

  mstate_t        mstate_q, mstate_d;
  logic [WCW-1:0] wait_cnt_q, wait_cnt_d;

  logic mem_access;
  logic wait_expired;
  logic mem_done;
  logic mem_stall;
  logic timeout_hit;
  logic load_use;

  // ---------------------------------------------------------------------------
  // Hazard detection
  // ---------------------------------------------------------------------------
  assign mem_access = mem_read | mem_write;

  // The FSM only has IDLE and WAIT, both of which may request; reset holds the
  // request low so an in-flight access is abandoned the moment reset rises.
  assign mem_req = mem_access & ~reset;

  assign wait_expired = (mstate_q == M_WAIT) && (wait_cnt_q == WAIT_LAST);

  // A timeout counts as completion: the pipeline moves on with undefined load
  // data rather than hanging, and mem_err records that it happened.
  assign mem_done    = mem_req & (mem_ready | wait_expired);
  assign mem_stall   = mem_req & ~mem_done;
  assign timeout_hit = mem_req & ~mem_ready & wait_expired;

  // x0 is hard-wired to zero, so a load targeting it never creates a hazard.
  assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                    ((ex_rd == id_rs1) || (ex_rd == id_rs2));

  // ---------------------------------------------------------------------------
  // Memory handshake FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mstate_q   <= M_IDLE;
      wait_cnt_q <= '0;
    end else begin
      mstate_q   <= mstate_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  always_comb begin
    mstate_d   = mstate_q;
    wait_cnt_d = wait_cnt_q;
    case (mstate_q)
      M_IDLE: begin
        if (mem_stall) begin
          mstate_d   = M_WAIT;
          wait_cnt_d = WCW'(1);
        end
      end
      M_WAIT: begin
        if (mem_stall) begin
          wait_cnt_d = wait_cnt_q + WCW'(1);
        end else begin
          // Completion, timeout, or the access disappearing all return to IDLE.
          mstate_d   = M_IDLE;
          wait_cnt_d = '0;
        end
      end
      default: begin
        mstate_d   = M_IDLE;
        wait_cnt_d = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Stage control, highest priority first
  // ---------------------------------------------------------------------------
  always_comb begin
    pc_write_en     = 1'b1;
    if_id_write_en  = 1'b1;
    id_ex_write_en  = 1'b1;
    ex_mem_write_en = 1'b1;
    if_id_flush     = 1'b0;
    id_ex_flush     = 1'b0;
    mem_wb_bubble   = 1'b0;

    if (reset) begin
      // Keep the idle defaults while reset is held.
    end else if (mem_stall) begin
      // Everything upstream of MEM is frozen, so a redirect or load-use seen
      // now is simply re-evaluated once the access completes.
      pc_write_en     = 1'b0;
      if_id_write_en  = 1'b0;
      id_ex_write_en  = 1'b0;
      ex_mem_write_en = 1'b0;
      mem_wb_bubble   = 1'b1;
    end else if (ex_redirect) begin
      // The ID instruction is killed, so any load-use it would cause is moot.
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (load_use) begin
      pc_write_en    = 1'b0;
      if_id_write_en = 1'b0;
      id_ex_flush    = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Sticky timeout flag and saturating performance counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_err <= 1'b0;
    end else if (timeout_hit) begin
      mem_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (!pc_write_en && (stall_cnt != CNT_MAX)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flush_cnt <= '0;
    end else if (if_id_flush && (flush_cnt != CNT_MAX)) begin
      flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Hazard and stall sequencer for the 5-stage RV32 pipeline. Sits beside the main decoder and consumes its MemRead/MemWrite/Branch/JalType results as they travel down the pipeline. It generates stage write-enables, flushes and bubbles for three cases: load-use hazards, taken control transfers, and a variable-latency data-memory handshake. It also provides a memory timeout flag and saturating stall/flush performance counters.

## Interface
- TIMEOUT, 16: maximum cycles one data-memory access may occupy the MEM stage; must be ≥ 2.
- CNT_W, 32: width of the performance counters.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- id_rs1, id_rs2  in  5  source register fields of the instruction in ID.
- ex_rd  in  5  destination register of the instruction in EX.
- ex_mem_read  in  1  MemRead of the instruction in EX (ID/EX register).
- ex_redirect  in  1  EX resolved a taken branch, or holds JAL/JALR.
- mem_read, mem_write  in  1  MemRead/MemWrite of the instruction in MEM (EX/MEM register).
- mem_ready  in  1  data memory completes the access this cycle.
- mem_req  out  1  data-memory request.
- pc_write_en, if_id_write_en, id_ex_write_en, ex_mem_write_en  out  1  stage register loads.
- if_id_flush, id_ex_flush  out  1  load NOP into IF/ID or ID/EX.
- mem_wb_bubble  out  1  load NOP into MEM/WB.
- mem_err  out  1  sticky memory-timeout flag.
- stall_cnt, flush_cnt  out  CNT_W  saturating counters.

## Operation
- Registered state: mstate ∈ {IDLE, WAIT}, wait_cnt, mem_err, stall_cnt, flush_cnt.
- mem_access = mem_read | mem_write.
- mem_req = mem_access & (mstate==IDLE | mstate==WAIT). Combinational. A transfer happens on an edge where mem_req & mem_ready.
- mem_done = mem_req & (mem_ready | (mstate==WAIT & wait_cnt==TIMEOUT-1)).
- mem_stall = mem_req & ~mem_done.
- load_use = ex_mem_read & ex_rd≠0 & (ex_rd==id_rs1 | ex_rd==id_rs2).
- Priority, highest first:
  - mem_stall: all write_ens = 0, if_id_flush = id_ex_flush = 0, mem_wb_bubble = 1. Any pending redirect or load-use is re-evaluated next cycle, because EX and ID are frozen.
  - ex_redirect: if_id_flush = 1, id_ex_flush = 1, all write_ens = 1. load_use is ignored because the ID instruction is being killed.
  - load_use: pc_write_en = 0, if_id_write_en = 0, id_ex_flush = 1, other write_ens = 1.
  - Otherwise: all write_ens = 1, no flush, no bubble.
- mstate transitions:
  - IDLE → WAIT when mem_stall; wait_cnt ← 1.
  - WAIT stays in WAIT while mem_stall; wait_cnt increments.
  - WAIT → IDLE on mem_done; wait_cnt ← 0.
  - IDLE stays in IDLE otherwise.
- Timeout: in WAIT with wait_cnt==TIMEOUT-1 and mem_ready=0:
  - The stall releases that cycle, so the instruction advances with undefined load data.
  - mem_err ← 1 on that edge and holds until reset.
  - mstate ← IDLE.
- stall_cnt increments on every edge with pc_write_en=0. flush_cnt increments on every edge with if_id_flush=1. Both saturate at 2^CNT_W−1 and never wrap.
- Back-to-back memory instructions: the next access issues mem_req in IDLE the cycle after the previous completion. An access is never re-requested once it has completed.

## Timing
- Reset values, with reset asserted at any time and asynchronously:
  - mstate = IDLE, wait_cnt = 0, mem_err = 0, stall_cnt = flush_cnt = 0.
  - mem_req = 0.
  - All write_ens = 1.
  - if_id_flush = id_ex_flush = mem_wb_bubble = 0.
- Reset during WAIT drops mem_req immediately and abandons the access.
- All control outputs are combinational from the current inputs and registered state, with zero-cycle latency.
- An access that gets mem_ready in its issue cycle costs 0 stall cycles.
- An access that gets mem_ready N cycles after issue (N < TIMEOUT) costs N stall cycles.
- A load-use hazard costs exactly 1 stall cycle.
- A redirect costs 2 flushed slots, in one cycle.
- Maximum stall per access is TIMEOUT−1 cycles.

## Test plan
- Load-use: ex_mem_read=1, ex_rd=5, id_rs2=5. Expect exactly one cycle of pc_write_en=0, if_id_write_en=0, id_ex_flush=1, and stall_cnt=1. Repeat with ex_rd=0: expect no stall.
- Redirect plus load-use in the same cycle: expect if_id_flush=id_ex_flush=1, pc_write_en=1, flush_cnt 0→1, stall_cnt unchanged.
- Load with mem_ready=1 in the issue cycle: expect mem_req=1 for 1 cycle, no stall, mstate stays IDLE.
- Store with mem_ready 3 cycles after issue: expect mem_stall and mem_wb_bubble high for 3 cycles, all write_ens=0, stall_cnt=3, and a redirect arriving meanwhile is applied only after release.
- TIMEOUT=4, mem_ready stuck at 0: expect 3 stall cycles, release on the 4th, mem_err=1 afterwards and still 1 after 10 further accesses. Reset clears it.
- Assert reset in cycle 2 of WAIT: expect mem_req=0 immediately, counters=0, and a clean new access after reset.
